sockit_ghrd_led_pio: RTL
========================

// Module: sockit_ghrd_led_pio
// PURPOSE
//   Avalon-MM slave output PIO that drives board LEDs. It is the output-side
//   counterpart of the DIP-switch/button input PIOs.
//   - Holds a CPU-written output data register with atomic set/clear access.
//   - Adds a hardware blink engine: selected bits toggle at a programmable
//     rate with no CPU involvement.
//   - Sits on the HPS lightweight bridge alongside the other PIOs.
// PARAMETERS
//   WIDTH        4       number of output bits (1..32)
//   RESET_VALUE  0       data register value after reset
//   PRESCALE     50000   clk cycles per blink tick (>=2; 1 ms at 50 MHz)
// PORTS
//   clk          in   1      system clock; all logic on rising edge
//   reset        in   1      synchronous, active-high reset
//   address      in   3      word address, map below
//   chipselect   in   1      slave select
//   write_n      in   1      active-low write strobe, qualified by chipselect
//   writedata    in   32     write data; bits [WIDTH-1:0] used unless noted
//   readdata     out  32     registered read data, zero-extended
//   out_port     out  WIDTH  LED drive
// BEHAVIOUR
//   Write strobe: wr = chipselect & ~write_n. Writes have no wait states.
//   Register map:
//     0 DATA     R/W  data_reg
//     1 BLINK    R/W  blink_mask; a 1 selects a bit for blinking
//     2 PERIOD   R/W  16-bit half-period in ticks; writedata[15:0]; 0 = off
//     3 PIN      RO   current out_port value
//     4 OUTSET   WO   data_reg <= data_reg | wd
//     5 OUTCLR   WO   data_reg <= data_reg & ~wd
//     6,7        reserved; read 0, writes ignored, except as noted under CONFIGURATION
//   Reads:
//     - readdata <= zero-extended mux(address) every cycle, chipselect ignored.
//     - 1-cycle latency.
//     - Write-only and reserved addresses read 0.
//   Reset values:
//     - data_reg=RESET_VALUE; blink_mask=0; PERIOD=0.
//     - phase=0; both counters=0; readdata=0.
//     - out_port=RESET_VALUE on the cycle after reset is sampled.
//   Output: out_port = data_reg ^ (blink_mask & {WIDTH{phase}}), combinational
//     from registers. A DATA/OUTSET/OUTCLR write is visible on out_port 1 clk
//     after the write cycle.
//   Blink engine:
//     - presc counts 0..PRESCALE-1 and wraps; tick=1 in the cycle presc==PRESCALE-1.
//     - On each tick, tcnt counts 0..PERIOD-1 and wraps.
//     - expire = tick & (tcnt==PERIOD-1); on expire, phase toggles.
//     - With PERIOD!=0, phase toggles every PRESCALE*PERIOD clks exactly.
//       The first toggle comes PRESCALE*PERIOD clks after the PERIOD write.
//     - PERIOD==0: presc, tcnt and phase are held at 0, and expire never fires.
//   Boundary and simultaneous events:
//     - A PERIOD write clears presc, tcnt and phase in the same edge. It wins
//       over a coincident expire, so phase does not toggle on that edge.
//     - Writing PERIOD with its current value still restarts the engine.
//     - BLINK write: takes effect next clk. phase continues and is not reset.
//     - Clearing a blink_mask bit returns that bit to data_reg at once.
//     - tcnt is 16 bits; PERIOD=0xFFFF gives 65535 ticks and no overflow.
//     - Reset asserted mid-period: all state returns to reset values on that edge.
// CONFIGURATION
//   LED_PIO_PULSE_EN defined:
//     - Address 6 PULSE (R/W) is added: pulse_reg.
//     - A write does pulse_reg <= (expire ? 0 : pulse_reg) | wd.
//     - If PERIOD==0 the write is ignored.
//     - Otherwise pulse_reg <= 0 on expire.
//     - out_port = (data_reg ^ (blink_mask & {WIDTH{phase}})) | pulse_reg.
//     - PERIOD write or reset clears pulse_reg.
//   LED_PIO_PULSE_EN undefined: no pulse logic; address 6 reads 0 and writes
//     are ignored.
// TESTING  (bench uses PRESCALE=4, WIDTH=4, RESET_VALUE=4'h0)
//   1 Reset held 3 clks, then released -> out_port=0; reads of 0..7 return 0.
//   2 Write DATA=0xA, OUTSET 0x1, OUTCLR 0x8, then read 0 -> out_port 0xA, 0xB,
//     0x3 one clk after each write. readdata=0x3 one clk after address=0.
//   3 BLINK=0x5, PERIOD=3 -> out_port alternates 0x3 / 0x6 every 12 clks, with
//     the first toggle 12 clks after the PERIOD write.
//   4 During case 3, rewrite PERIOD=3 on the exact expire cycle -> no toggle on
//     that edge; next toggle 12 clks later. PERIOD=0 -> out_port frozen at 0x3.
//   5 Assert reset mid-blink with phase=1 -> next clk out_port=0, PERIOD=0,
//     BLINK=0, counters 0.
//   6 (PULSE_EN) DATA=0, BLINK=0, PERIOD=2, write PULSE=0x2 -> out_port=0x2
//     until the next expire (<=8 clks), then 0x0. With PERIOD=0, the same write
//     leaves out_port=0x0.

Source files
------------

// File: rtl/sockit_ghrd_led_pio.sv
// Avalon-MM output PIO for board LEDs: data register with atomic set/clear and a
// hardware blink engine. Defining LED_PIO_PULSE_EN adds a one-shot PULSE register.
module sockit_ghrd_led_pio #(
   parameter int                 WIDTH       = 4,
   parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}},
   parameter int                 PRESCALE    = 50000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic [WIDTH-1:0]  out_port
);

   localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

   logic [WIDTH-1:0] data_q,   data_d;
   logic [WIDTH-1:0] blink_q,  blink_d;
   logic [15:0]      period_q, period_d;
   logic [PW-1:0]    presc_q,  presc_d;
   logic [15:0]      tcnt_q,   tcnt_d;
   logic             phase_q,  phase_d;
   logic [31:0]      readdata_q, readdata_d;
   logic [WIDTH-1:0] pulse_q,  pulse_d;

   logic             wr_s;
   logic             period_wr_s;
   logic             tick_s;
   logic             expire_s;
   logic [WIDTH-1:0] wd_s;
   logic [WIDTH-1:0] pin_s;

   assign wr_s        = chipselect & ~write_n;
   assign wd_s        = writedata[WIDTH-1:0];
   assign period_wr_s = wr_s & (address == 3'd2);
   assign tick_s      = (period_q != 16'd0) & (presc_q == PRESC_LAST);
   assign expire_s    = tick_s & (tcnt_q == (period_q - 16'd1));

`ifdef LED_PIO_PULSE_EN
   assign pin_s = (data_q ^ (blink_q & {WIDTH{phase_q}})) | pulse_q;
`else
   assign pin_s = data_q ^ (blink_q & {WIDTH{phase_q}});
`endif
   assign out_port = pin_s;
   assign readdata = readdata_q;

   // Register-file next state for CPU-visible registers.
   always_comb begin
      data_d   = data_q;
      blink_d  = blink_q;
      period_d = period_q;
      if (wr_s) begin
         case (address)
            3'd0:    data_d   = wd_s;
            3'd1:    blink_d  = wd_s;
            3'd2:    period_d = writedata[15:0];
            3'd4:    data_d   = data_q | wd_s;
            3'd5:    data_d   = data_q & ~wd_s;
            default: data_d   = data_q;
         endcase
      end else begin
         data_d = data_q;
      end
   end

   // Blink engine; a PERIOD write restarts it and beats a coincident expire.
   always_comb begin
      presc_d = presc_q;
      tcnt_d  = tcnt_q;
      phase_d = phase_q;
      if (period_wr_s || (period_q == 16'd0)) begin
         presc_d = {PW{1'b0}};
         tcnt_d  = 16'd0;
         phase_d = 1'b0;
      end else if (tick_s) begin
         presc_d = {PW{1'b0}};
         tcnt_d  = expire_s ? 16'd0 : (tcnt_q + 16'd1);
         phase_d = expire_s ? ~phase_q : phase_q;
      end else begin
         presc_d = presc_q + PW'(1);
      end
   end

   // One-shot pulse bits, cleared on expire or PERIOD write.
   always_comb begin
      pulse_d = pulse_q;
`ifdef LED_PIO_PULSE_EN
      if (period_wr_s) begin
         pulse_d = {WIDTH{1'b0}};
      end else if (wr_s && (address == 3'd6) && (period_q != 16'd0)) begin
         pulse_d = (expire_s ? {WIDTH{1'b0}} : pulse_q) | wd_s;
      end else if (expire_s) begin
         pulse_d = {WIDTH{1'b0}};
      end else begin
         pulse_d = pulse_q;
      end
`else
      pulse_d = {WIDTH{1'b0}};
`endif
   end

   // Read mux, zero-extended; write-only and reserved addresses read 0.
   always_comb begin
      readdata_d = 32'd0;
      case (address)
         3'd0:    readdata_d = 32'(data_q);
         3'd1:    readdata_d = 32'(blink_q);
         3'd2:    readdata_d = {16'd0, period_q};
         3'd3:    readdata_d = 32'(pin_s);
`ifdef LED_PIO_PULSE_EN
         3'd6:    readdata_d = 32'(pulse_q);
`endif
         default: readdata_d = 32'd0;
      endcase
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_q     <= RESET_VALUE;
         blink_q    <= {WIDTH{1'b0}};
         period_q   <= 16'd0;
         presc_q    <= {PW{1'b0}};
         tcnt_q     <= 16'd0;
         phase_q    <= 1'b0;
         readdata_q <= 32'd0;
         pulse_q    <= {WIDTH{1'b0}};
      end else begin
         data_q     <= data_d;
         blink_q    <= blink_d;
         period_q   <= period_d;
         presc_q    <= presc_d;
         tcnt_q     <= tcnt_d;
         phase_q    <= phase_d;
         readdata_q <= readdata_d;
         pulse_q    <= pulse_d;
      end
   end

endmodule
